// File: rtl/hybrid_pkg.sv
// Shared types and helpers for the HybridCore output serializer.
// Holds the block geometry, transform-select encodings and the reader state type.
package hybrid_pkg;

    localparam int NPT    = 8;
    localparam int IDXW   = 3;
    localparam int CPLX_W = 12;

    typedef struct packed {
        logic [CPLX_W-1:0] re;
        logic [CPLX_W-1:0] im;
    } cplx_t;

    localparam logic [1:0] TSEL_FFT  = 2'b00;
    localparam logic [1:0] TSEL_IFFT = 2'b01;
    localparam logic [1:0] TSEL_DCT  = 2'b10;
    localparam logic [1:0] TSEL_WHT  = 2'b11;

    // Encoding equals the number of occupied banks.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FULL  = 2'd2
    } rd_state_e;

    function automatic logic [IDXW-1:0] bitrev3(input logic [IDXW-1:0] p);
        return {p[0], p[1], p[2]};
    endfunction

endpackage

// File: rtl/hybrid_bank_buf.sv
// Two-bank storage of 8-point complex blocks plus their transform tags.
// One parallel write port for a whole block, one combinational read mux for a single point.
module hybrid_bank_buf
    import hybrid_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic              wr_bank_i,
    input  logic [NPT*DW-1:0] wr_re_i,
    input  logic [NPT*DW-1:0] wr_im_i,
    input  logic [1:0]        wr_tag_i,
    input  logic              rd_bank_i,
    input  logic [IDXW-1:0]   rd_idx_i,
    output logic [DW-1:0]     rd_re_o,
    output logic [DW-1:0]     rd_im_o,
    output logic [1:0]        rd_tag_o
);

    logic [DW-1:0] re_q  [2][NPT];
    logic [DW-1:0] im_q  [2][NPT];
    logic [1:0]    tag_q [2];

    // Data storage carries no reset; it is never observed until a capture fills it.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int i = 0; i < NPT; i++) begin
                re_q[wr_bank_i][i] <= wr_re_i[i*DW +: DW];
                im_q[wr_bank_i][i] <= wr_im_i[i*DW +: DW];
            end
            tag_q[wr_bank_i] <= wr_tag_i;
        end
    end

    assign rd_re_o  = re_q[rd_bank_i][rd_idx_i];
    assign rd_im_o  = im_q[rd_bank_i][rd_idx_i];
    assign rd_tag_o = tag_q[rd_bank_i];

endmodule

// File: rtl/hybrid_out_serializer.sv
// Captures 8-point complex result blocks into a double buffer and streams them out
// one sample per accepted cycle over valid/ready, tagged with the capture-time t_select.
module hybrid_out_serializer
    import hybrid_pkg::*;
#(
    parameter int DW     = 12,
    parameter int BITREV = 0
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    t_select,
    input  logic [DW-1:0] rO0,
    input  logic [DW-1:0] rO1,
    input  logic [DW-1:0] rO2,
    input  logic [DW-1:0] rO3,
    input  logic [DW-1:0] rO4,
    input  logic [DW-1:0] rO5,
    input  logic [DW-1:0] rO6,
    input  logic [DW-1:0] rO7,
    input  logic [DW-1:0] iO0,
    input  logic [DW-1:0] iO1,
    input  logic [DW-1:0] iO2,
    input  logic [DW-1:0] iO3,
    input  logic [DW-1:0] iO4,
    input  logic [DW-1:0] iO5,
    input  logic [DW-1:0] iO6,
    input  logic [DW-1:0] iO7,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [2:0]    out_idx,
    output logic [1:0]    out_tsel,
    output logic          out_first,
    output logic          out_last,
    output logic          ovf
);

    rd_state_e       state_q, state_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [IDXW-1:0] pos_q, pos_d;
    logic            ovf_q, ovf_d;

    logic            capture, step, bank_free;
    logic [IDXW-1:0] rd_idx;
    logic [DW-1:0]   rd_re, rd_im;
    logic [1:0]      rd_tag;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign capture   = in_valid && in_ready;
    assign step      = out_valid && out_ready;
    assign bank_free = step && (pos_q == IDXW'(NPT-1));
    assign rd_idx    = (BITREV != 0) ? bitrev3(pos_q) : pos_q;

    hybrid_bank_buf #(.DW(DW)) u_bank (
        .clk_i     (CLK),
        .wr_en_i   (capture),
        .wr_bank_i (wr_ptr_q),
        .wr_re_i   ({rO7, rO6, rO5, rO4, rO3, rO2, rO1, rO0}),
        .wr_im_i   ({iO7, iO6, iO5, iO4, iO3, iO2, iO1, iO0}),
        .wr_tag_i  (t_select),
        .rd_bank_i (rd_ptr_q),
        .rd_idx_i  (rd_idx),
        .rd_re_o   (rd_re),
        .rd_im_o   (rd_im),
        .rd_tag_o  (rd_tag)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            pos_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pos_q    <= pos_d;
            ovf_q    <= ovf_d;
        end
    end

    // A capture and a free on the same edge cancel, keeping the occupancy unchanged.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q ^ capture;
        rd_ptr_d = rd_ptr_q ^ bank_free;
        pos_d    = step ? pos_q + IDXW'(1) : pos_q;
        ovf_d    = ovf_q | (in_valid && !in_ready);
        unique case (state_q)
            ST_EMPTY: if (capture) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (capture && !bank_free)      state_d = ST_FULL;
                else if (bank_free && !capture) state_d = ST_EMPTY;
            end
            ST_FULL:  if (bank_free) state_d = ST_DRAIN;
            default:  state_d = ST_EMPTY;
        endcase
    end

    assign out_re    = out_valid ? rd_re  : '0;
    assign out_im    = out_valid ? rd_im  : '0;
    assign out_idx   = out_valid ? rd_idx : '0;
    assign out_tsel  = out_valid ? rd_tag : '0;
    assign out_first = out_valid && (pos_q == '0);
    assign out_last  = out_valid && (pos_q == IDXW'(NPT-1));
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_hybrid_out_serializer.sv
// Bench for hybrid_out_serializer: two instances (natural and bit-reversed order) share
// the stimulus and are checked every cycle against a queue-of-blocks reference model.
module tb_hybrid_out_serializer;
    import hybrid_pkg::*;

    localparam int DW = 12;

    logic          CLK = 1'b0;
    logic          RESET, in_valid, out_ready;
    logic [1:0]    t_select;
    logic [DW-1:0] rin [8];
    logic [DW-1:0] iin [8];

    logic          ir0, v0, fi0, la0, ov0;
    logic [DW-1:0] re0, im0;
    logic [2:0]    idx0;
    logic [1:0]    ts0;
    logic          ir1, v1, fi1, la1, ov1;
    logic [DW-1:0] re1, im1;
    logic [2:0]    idx1;
    logic [1:0]    ts1;

    always #5 CLK = ~CLK;

    hybrid_out_serializer #(.DW(DW), .BITREV(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(ir0), .t_select(t_select),
        .rO0(rin[0]), .rO1(rin[1]), .rO2(rin[2]), .rO3(rin[3]),
        .rO4(rin[4]), .rO5(rin[5]), .rO6(rin[6]), .rO7(rin[7]),
        .iO0(iin[0]), .iO1(iin[1]), .iO2(iin[2]), .iO3(iin[3]),
        .iO4(iin[4]), .iO5(iin[5]), .iO6(iin[6]), .iO7(iin[7]),
        .out_valid(v0), .out_ready(out_ready), .out_re(re0), .out_im(im0), .out_idx(idx0),
        .out_tsel(ts0), .out_first(fi0), .out_last(la0), .ovf(ov0)
    );

    hybrid_out_serializer #(.DW(DW), .BITREV(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(ir1), .t_select(t_select),
        .rO0(rin[0]), .rO1(rin[1]), .rO2(rin[2]), .rO3(rin[3]),
        .rO4(rin[4]), .rO5(rin[5]), .rO6(rin[6]), .rO7(rin[7]),
        .iO0(iin[0]), .iO1(iin[1]), .iO2(iin[2]), .iO3(iin[3]),
        .iO4(iin[4]), .iO5(iin[5]), .iO6(iin[6]), .iO7(iin[7]),
        .out_valid(v1), .out_ready(out_ready), .out_re(re1), .out_im(im1), .out_idx(idx1),
        .out_tsel(ts1), .out_first(fi1), .out_last(la1), .ovf(ov1)
    );

    typedef struct packed {
        logic [1:0]      tag;
        cplx_t [7:0]     pt;
    } blk_t;

    blk_t mq [$];
    int   mpos;
    logic movf;
    int   tests;
    int   fails;
    int   br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpos = 0;
        movf = 1'b0;
    endtask

    function automatic blk_t cur_blk();
        blk_t b;
        for (int i = 0; i < 8; i++) begin
            b.pt[i].re = rin[i];
            b.pt[i].im = iin[i];
        end
        b.tag = t_select;
        return b;
    endfunction

    task automatic set_blk();
        for (int i = 0; i < 8; i++) begin
            rin[i] = DW'($urandom);
            iin[i] = DW'($urandom);
        end
    endtask

    task automatic check_one(input string p, input bit rev, input logic v, input logic ir,
                             input logic [DW-1:0] re, input logic [DW-1:0] im,
                             input logic [2:0] idx, input logic [1:0] ts,
                             input logic fi, input logic la, input logic ov);
        bit   ev;
        int   id;
        blk_t b;
        ev = (mq.size() > 0);
        chk({p, "_valid"}, 32'(v), 32'(ev));
        chk({p, "_in_ready"}, 32'(ir), 32'(mq.size() < 2));
        chk({p, "_ovf"}, 32'(ov), 32'(movf));
        if (ev) begin
            b  = mq[0];
            id = rev ? br[mpos] : mpos;
            chk({p, "_re"}, 32'(re), 32'(b.pt[id].re));
            chk({p, "_im"}, 32'(im), 32'(b.pt[id].im));
            chk({p, "_idx"}, 32'(idx), id);
            chk({p, "_tsel"}, 32'(ts), 32'(b.tag));
            chk({p, "_first"}, 32'(fi), 32'(mpos == 0));
            chk({p, "_last"}, 32'(la), 32'(mpos == 7));
        end else begin
            chk({p, "_re_idle"}, 32'(re), 0);
            chk({p, "_im_idle"}, 32'(im), 0);
            chk({p, "_idx_idle"}, 32'(idx), 0);
            chk({p, "_tsel_idle"}, 32'(ts), 0);
            chk({p, "_flags_idle"}, 32'({fi, la}), 0);
        end
    endtask

    task automatic check_both();
        check_one("d0", 1'b0, v0, ir0, re0, im0, idx0, ts0, fi0, la0, ov0);
        check_one("d1", 1'b1, v1, ir1, re1, im1, idx1, ts1, fi1, la1, ov1);
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        bit   ev, cap, drop, fr;
        blk_t nb;
        #1;
        check_both();
        ev   = (mq.size() > 0);
        cap  = in_valid && (mq.size() < 2);
        drop = in_valid && (mq.size() >= 2);
        fr   = ev && out_ready && (mpos == 7);
        nb   = cur_blk();
        @(posedge CLK);
        if (ev && out_ready) mpos = (mpos + 1) % 8;
        if (fr) void'(mq.pop_front());
        if (cap) mq.push_back(nb);
        if (drop) movf = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tests     = 0;
        fails     = 0;
        RESET     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        t_select  = 2'b00;
        for (int i = 0; i < 8; i++) begin
            rin[i] = '0;
            iin[i] = '0;
        end
        model_reset();

        // Reset state
        #2 RESET = 1'b0;
        #1;
        check_both();
        #19;
        @(negedge CLK);
        RESET = 1'b1;

        // Scenario 1/2: known block, natural and bit-reversed order
        for (int i = 0; i < 8; i++) begin
            rin[i] = DW'(10 - i);
            iin[i] = DW'(i);
        end
        t_select  = TSEL_DCT;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("s1_re", 32'(re0), 10 - k);
            chk("s1_im", 32'(im0), k);
            chk("s1_first", 32'(fi0), 32'(k == 0));
            chk("s1_last", 32'(la0), 32'(k == 7));
            chk("s1_tsel", 32'(ts0), 2);
            chk("s2_idx", 32'(idx1), br[k]);
            chk("s2_re", 32'(re1), 10 - br[k]);
            step();
        end
        chk("s1_done", 32'(v0), 0);

        // Scenario 3: backpressure holds sample 0
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (5) begin
            chk("s3_hold_re", 32'(re0), 10);
            chk("s3_hold_first", 32'(fi0), 1);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("s3_resume", 32'(re0), 9);
        repeat (7) step();
        chk("s3_done", 32'(v0), 0);

        // Scenario 4: double buffer and overflow
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_blk(); t_select = 2'b01; step();
        set_blk(); t_select = 2'b11; step();
        chk("s4_full", 32'(ir0), 0);
        set_blk(); t_select = 2'b00; step();
        in_valid = 1'b0;
        chk("s4_ovf", 32'(ov0), 1);
        out_ready = 1'b1;
        chk("s4_tag1", 32'(ts0), 1);
        repeat (8) step();
        chk("s4_tag2", 32'(ts0), 3);
        repeat (8) step();
        chk("s4_empty", 32'(v0), 0);

        // Scenario 5: capture coincides with the out_last handshake
        set_blk(); t_select = 2'b01; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk("s5_last", 32'(la0), 1);
        set_blk(); t_select = 2'b10; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("s5_first", 32'(fi0), 1);
        chk("s5_valid", 32'(v0), 1);
        chk("s5_tsel", 32'(ts0), 2);
        chk("s5_one_bank", 32'(ir0), 1);
        repeat (8) step();

        // Scenario 6: reset mid-drain
        set_blk(); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        #2 RESET = 1'b0;
        #1;
        chk("s6_valid", 32'(v0), 0);
        chk("s6_ready", 32'(ir0), 1);
        chk("s6_ovf", 32'(ov0), 0);
        chk("s6_valid_br", 32'(v1), 0);
        model_reset();
        @(negedge CLK);
        RESET = 1'b1;
        set_blk(); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("s6_first", 32'(fi0), 1);
        chk("s6_idx", 32'(idx0), 0);
        repeat (8) step();

        // Randomized traffic against the model
        repeat (400) begin
            set_blk();
            t_select  = 2'($urandom);
            in_valid  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
